ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Four-master AHB bus arbiter for the bus segment. It samples the master bus requests and lock requests and issues one-hot grants. It also drives the HMASTER / HMASTERD select codes consumed by the master-to-slave multiplexer, so the address-phase and data-phase muxes always follow the bus owner. Master 1 is the default master: it is granted whenever no master requests.

## Interface
Parameters:
- none; master count fixed at 4 (codes 4'h0–4'h3), default master fixed at 4'h1.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HBUSREQx0..HBUSREQx3  in  1 each  bus request from master n.
- HLOCKx0..HLOCKx3  in  1 each  locked-transfer request from master n.
- HTRANS  in  2  muxed transfer type of current address phase (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  in  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- HREADY  in  1  bus ready; transfer phases advance only when 1.
- HGRANTx0..HGRANTx3  out  1 each  one-hot grant, registered.
- HMASTER  out  4  address-phase owner code, registered.
- HMASTERD  out  4  data-phase owner code, registered (HMASTER delayed by one HREADY-qualified cycle).
- HMASTLOCK  out  1  current address phase is locked, registered.

## Operation
- Reset values: HGRANTx1=1, HGRANTx0/2/3=0, HMASTER=4'h1, HMASTERD=4'h1, HMASTLOCK=0, beat counter=0, last-grant pointer=4'h1.
- Beat counter (4 bits) tracks remaining beats of a fixed-length burst. It updates only when HREADY=1:
  - NONSEQ loads 0 for SINGLE/INCR, 3 for x4, 7 for x8, 15 for x16.
  - SEQ decrements when nonzero.
  - IDLE clears to 0.
  - BUSY holds.
- Arbitration point: HREADY=1 and not locked, and one of:
  - HTRANS=IDLE;
  - HTRANS=NONSEQ with counter load value 0;
  - HTRANS=SEQ with counter=1;
  - HTRANS=BUSY with counter=0.
- Locked: the current grantee has both HLOCKx and HBUSREQx asserted. While locked, the grant never changes, even at a burst end.
- At an arbitration point, the grant updates to the selected requester. With no requester, master 1 is selected. Re-granting the same master is allowed and is not a handover.
- Selection without the macro is fixed priority: 0 > 1 > 2 > 3.
- A master dropping HBUSREQx mid fixed-length burst does not lose the grant until the arbitration point. An early-terminated burst (IDLE or NONSEQ mid-burst) reloads or clears the counter as above, so arbitration proceeds on the new value.
- HGRANTx outputs are always exactly one-hot.

## Timing
- Grant latency: a request seen at an arbitration-point edge drives HGRANTx high in the next cycle.
- HMASTER <= index of the HGRANTx currently asserted, on each edge with HREADY=1. The newly granted master therefore owns the address phase on the first HREADY-high edge after its grant rises.
- HMASTERD <= HMASTER on each edge with HREADY=1. Data ownership trails address ownership by exactly one completed transfer.
- HMASTLOCK <= HLOCKx of the granted master, on each edge with HREADY=1.
- HREADY=0 freezes the counter, grant, HMASTER, HMASTERD and HMASTLOCK.
- Reset assertion mid-burst immediately forces all reset values, independent of HCLK.

## Configuration
- AHB_ARB_ROUND_ROBIN_EN defined: the last-grant pointer records the code of every new non-default grant. The search order starts at pointer+1 and wraps modulo 4, so a requester waits at most 3 handovers. The no-request fallback remains master 1.
- AHB_ARB_ROUND_ROBIN_EN undefined: fixed priority 0 > 1 > 2 > 3; the pointer logic is not compiled.

## Test plan
- Reset with no requests: after HRESETn rises, HGRANTx1=1, HMASTER=HMASTERD=4'h1 and HMASTLOCK=0, held for 10 cycles.
- Master 2 requests and issues INCR4 (NONSEQ then 3×SEQ, HREADY=1); master 0 requests at beat 2. Required response:
  - HGRANTx2 is held through the burst.
  - HGRANTx0 rises in the cycle after the SEQ beat with counter=1.
  - HMASTER=4'h0 one HREADY edge later, and HMASTERD=4'h0 one edge after that.
- HREADY=0 for 3 cycles mid-burst: counter, grant, HMASTER and HMASTERD are unchanged; progress resumes when HREADY=1.
- Master 3 asserts HLOCKx3 and HBUSREQx3 across two SINGLE transfers while master 0 requests. Required response: HGRANTx3 is held throughout and HMASTLOCK=1; master 0 is granted only after HLOCKx3 falls.
- All four masters request continuously with SINGLE transfers:
  - with AHB_ARB_ROUND_ROBIN_EN, the grant order is 2,3,0,1,2…;
  - without it, master 0 holds the grant every cycle.
- Reset asserted during WRAP8 beat 5: outputs take reset values asynchronously, and the counter reads 0 after release.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Four-master AHB arbiter: one-hot grants plus HMASTER/HMASTERD owner codes.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin selection; default build is fixed priority 0>1>2>3.
module ahb_arbiter (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HBUSREQx0,
  input  logic       HBUSREQx1,
  input  logic       HBUSREQx2,
  input  logic       HBUSREQx3,
  input  logic       HLOCKx0,
  input  logic       HLOCKx1,
  input  logic       HLOCKx2,
  input  logic       HLOCKx3,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic       HGRANTx0,
  output logic       HGRANTx1,
  output logic       HGRANTx2,
  output logic       HGRANTx3,
  output logic [3:0] HMASTER,
  output logic [3:0] HMASTERD,
  output logic       HMASTLOCK
);

  localparam int unsigned NM = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned MW = 4;
  localparam logic [MW-1:0] DEF_MASTER = MW'(1);
  localparam logic [NM-1:0] DEF_GNT    = NM'(2);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [NM-1:0] req_c, lock_c, gnt, gnt_nxt_c;
  logic [CW-1:0] cnt, cnt_load_c, cnt_nxt_c;
  logic [MW-1:0] gnt_idx_c;
  logic [1:0]    sel_c;
  logic          locked_c, arb_c;

  assign req_c  = {HBUSREQx3, HBUSREQx2, HBUSREQx1, HBUSREQx0};
  assign lock_c = {HLOCKx3, HLOCKx2, HLOCKx1, HLOCKx0};

  // Owner code of the current one-hot grant
  always_comb begin
    gnt_idx_c = DEF_MASTER;
    case (gnt)
      4'b0001: gnt_idx_c = MW'(0);
      4'b0010: gnt_idx_c = MW'(1);
      4'b0100: gnt_idx_c = MW'(2);
      4'b1000: gnt_idx_c = MW'(3);
      default: gnt_idx_c = DEF_MASTER;
    endcase
  end

  // Remaining-beat load value for a NONSEQ start
  always_comb begin
    cnt_load_c = '0;
    case (HBURST)
      3'd0, 3'd1: cnt_load_c = CW'(0);
      3'd2, 3'd3: cnt_load_c = CW'(3);
      3'd4, 3'd5: cnt_load_c = CW'(7);
      default:    cnt_load_c = CW'(15);
    endcase
  end

  always_comb begin
    cnt_nxt_c = cnt;
    case (HTRANS)
      TR_IDLE:   cnt_nxt_c = '0;
      TR_NONSEQ: cnt_nxt_c = cnt_load_c;
      TR_SEQ:    cnt_nxt_c = (cnt != '0) ? cnt - CW'(1) : cnt;
      default:   cnt_nxt_c = cnt;
    endcase
  end

  assign locked_c = |(gnt & req_c & lock_c);

  always_comb begin
    arb_c = 1'b0;
    if (HREADY && !locked_c) begin
      case (HTRANS)
        TR_IDLE:   arb_c = 1'b1;
        TR_NONSEQ: arb_c = (cnt_load_c == '0);
        TR_SEQ:    arb_c = (cnt == CW'(1));
        default:   arb_c = (cnt == '0);
      endcase
    end
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;
  logic [1:0] rr_idx_c;

  // Search from ptr+1 upward; descending loop leaves the nearest requester in sel_c
  always_comb begin
    sel_c    = DEF_MASTER[1:0];
    rr_idx_c = '0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx_c = ptr + 2'(k);
      if (req_c[rr_idx_c]) sel_c = rr_idx_c;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)               ptr <= DEF_MASTER[1:0];
    else if (arb_c && |req_c)   ptr <= sel_c;
  end
`else
  always_comb begin
    sel_c = DEF_MASTER[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (req_c[i]) sel_c = 2'(i);
    end
  end
`endif

  assign gnt_nxt_c = NM'(1) << sel_c;

  // Grant, owner pipeline and burst counter all freeze while HREADY is low
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt       <= DEF_GNT;
      cnt       <= '0;
      HMASTER   <= DEF_MASTER;
      HMASTERD  <= DEF_MASTER;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      cnt       <= cnt_nxt_c;
      HMASTER   <= gnt_idx_c;
      HMASTERD  <= HMASTER;
      HMASTLOCK <= |(gnt & lock_c);
      if (arb_c) gnt <= gnt_nxt_c;
    end
  end

  assign HGRANTx0 = gnt[0];
  assign HGRANTx1 = gnt[1];
  assign HGRANTx2 = gnt[2];
  assign HGRANTx3 = gnt[3];

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed vector table, hand sequences, and
// randomized traffic compared each cycle against a rule-level reference model.
module tb_ahb_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic       g0, g1, g2, g3;
  logic [3:0] hmaster, hmasterd;
  logic       hmastlock;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQx0(req[0]), .HBUSREQx1(req[1]), .HBUSREQx2(req[2]), .HBUSREQx3(req[3]),
    .HLOCKx0(lock[0]), .HLOCKx1(lock[1]), .HLOCKx2(lock[2]), .HLOCKx3(lock[3]),
    .HTRANS(trans), .HBURST(burst), .HREADY(ready),
    .HGRANTx0(g0), .HGRANTx1(g1), .HGRANTx2(g2), .HGRANTx3(g3),
    .HMASTER(hmaster), .HMASTERD(hmasterd), .HMASTLOCK(hmastlock)
  );

  wire [3:0] gv = {g3, g2, g1, g0};

  // ---------------- reference model ----------------
  int m_grant, m_master, m_masterd, m_ptr, m_beats;
  bit m_lock;

  function automatic int burst_load(logic [2:0] b);
    int beats_in_burst;
    beats_in_burst = (b < 3'd2) ? 1 : (2 << (b >> 1));
    return beats_in_burst - 1;
  endfunction

  function automatic int pick(logic [3:0] r, int ptr);
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`else
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`endif
    return 1;
  endfunction

  function automatic bit model_arb();
    if (lock[m_grant] && req[m_grant]) return 0;
    case (trans)
      2'd0:    return 1;
      2'd2:    return burst_load(burst) == 0;
      2'd3:    return m_beats == 1;
      default: return m_beats == 0;
    endcase
  endfunction

  function automatic int next_beats();
    case (trans)
      2'd0:    return 0;
      2'd2:    return burst_load(burst);
      2'd3:    return (m_beats > 0) ? m_beats - 1 : 0;
      default: return m_beats;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_grant <= 1; m_master <= 1; m_masterd <= 1; m_lock <= 0; m_beats <= 0; m_ptr <= 1;
    end else if (ready) begin
      m_beats   <= next_beats();
      m_master  <= m_grant;
      m_masterd <= m_master;
      m_lock    <= lock[m_grant];
      if (model_arb()) begin
        m_grant <= pick(req, m_ptr);
        if (req != 4'd0) m_ptr <= pick(req, m_ptr);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = 4'(1 << m_grant);
    check({tag, "_grant"}, int'(gv), int'(eg));
    check({tag, "_onehot"}, $countones(gv), 1);
    check({tag, "_hmaster"}, int'(hmaster), m_master);
    check({tag, "_hmasterd"}, int'(hmasterd), m_masterd);
    check({tag, "_hmastlock"}, int'(hmastlock), int'(m_lock));
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                       input logic [2:0] b, input logic rdy);
    req = r; lock = l; trans = t; burst = b; ready = rdy;
  endtask

  task automatic cycle(input string tag);
    @(posedge HCLK);
    @(negedge HCLK);
    check_model(tag);
  endtask

  task automatic reset_pulse();
    @(negedge HCLK);
    drive(4'h0, 4'h0, 2'd0, 3'd0, 1'b1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;  logic [3:0] lock; logic [1:0] trans; logic [2:0] burst; logic ready;
    logic [3:0] gnt;  logic [3:0] mst;  logic [3:0] mstd;  logic mlk;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic [1:0] t, logic [2:0] b, logic rdy,
                              logic [3:0] g, logic [3:0] m, logic [3:0] d);
    vec_t v;
    v.req = r; v.lock = 4'h0; v.trans = t; v.burst = b; v.ready = rdy;
    v.gnt = g; v.mst = m; v.mstd = d; v.mlk = 1'b0;
    return v;
  endfunction

  vec_t tbl[15];
  int   exp_rr;

  initial begin
    // master 2 INCR4 with master 0 joining at beat 2, then INCR8 stalled and aborted
    tbl[0]  = mk(4'b0100, 2'd0, 3'd0, 1, 4'b0100, 4'h1, 4'h1);
    tbl[1]  = mk(4'b0100, 2'd0, 3'd0, 1, 4'b0100, 4'h2, 4'h1);
    tbl[2]  = mk(4'b0100, 2'd2, 3'd3, 1, 4'b0100, 4'h2, 4'h2);
    tbl[3]  = mk(4'b0101, 2'd3, 3'd3, 1, 4'b0100, 4'h2, 4'h2);
    tbl[4]  = mk(4'b0101, 2'd3, 3'd3, 1, 4'b0100, 4'h2, 4'h2);
    tbl[5]  = mk(4'b0101, 2'd3, 3'd3, 1, 4'b0001, 4'h2, 4'h2);
    tbl[6]  = mk(4'b0001, 2'd0, 3'd0, 1, 4'b0001, 4'h0, 4'h2);
    tbl[7]  = mk(4'b0001, 2'd2, 3'd0, 1, 4'b0001, 4'h0, 4'h0);
    tbl[8]  = mk(4'b0001, 2'd2, 3'd5, 1, 4'b0001, 4'h0, 4'h0);
    tbl[9]  = mk(4'b0011, 2'd3, 3'd5, 1, 4'b0001, 4'h0, 4'h0);
    tbl[10] = mk(4'b0011, 2'd3, 3'd5, 0, 4'b0001, 4'h0, 4'h0);
    tbl[11] = mk(4'b0010, 2'd0, 3'd5, 0, 4'b0001, 4'h0, 4'h0);
    tbl[12] = mk(4'b0010, 2'd0, 3'd5, 0, 4'b0001, 4'h0, 4'h0);
    tbl[13] = mk(4'b0011, 2'd3, 3'd5, 1, 4'b0001, 4'h0, 4'h0);
    tbl[14] = mk(4'b0010, 2'd0, 3'd5, 1, 4'b0010, 4'h0, 4'h0);

    // reset with no requests, held for 10 cycles
    drive(4'h0, 4'h0, 2'd0, 3'd0, 1'b1);
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); @(negedge HCLK);
      check("rst_grant", int'(gv), 2);
      check("rst_hmaster", int'(hmaster), 1);
      check("rst_hmasterd", int'(hmasterd), 1);
      check("rst_hmastlock", int'(hmastlock), 0);
    end

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].ready);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_tgrant", i), int'(gv), int'(tbl[i].gnt));
      check($sformatf("vec%0d_thmaster", i), int'(hmaster), int'(tbl[i].mst));
      check($sformatf("vec%0d_thmasterd", i), int'(hmasterd), int'(tbl[i].mstd));
      check($sformatf("vec%0d_tlock", i), int'(hmastlock), int'(tbl[i].mlk));
    end

    // master 3 locked across two SINGLE transfers while master 0 waits
    drive(4'b1000, 4'b1000, 2'd0, 3'd0, 1); cycle("lk0");
    check("lk0_grant", int'(gv), 8);
    drive(4'b1001, 4'b1000, 2'd0, 3'd0, 1); cycle("lk1");
    check("lk1_grant", int'(gv), 8); check("lk1_mlock", int'(hmastlock), 1);
    for (int i = 0; i < 2; i++) begin
      drive(4'b1001, 4'b1000, 2'd2, 3'd0, 1); cycle("lk2");
      check("lk2_grant", int'(gv), 8); check("lk2_mlock", int'(hmastlock), 1);
    end
    drive(4'b1001, 4'b0000, 2'd2, 3'd0, 1); cycle("lk3");
    check("lk3_grant", int'(gv), 1); check("lk3_mlock", int'(hmastlock), 0);

    // async reset during WRAP8 beat 5
    drive(4'b0100, 4'h0, 2'd0, 3'd0, 1); cycle("ar0"); cycle("ar1");
    check("ar1_grant", int'(gv), 4);
    drive(4'b0100, 4'h0, 2'd2, 3'd4, 1); cycle("ar2");
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 4'h0, 2'd3, 3'd4, 1); cycle("ar3");
    end
    drive(4'b0100, 4'h0, 2'd3, 3'd4, 1);
    #2 HRESETn = 1'b0;
    #1;
    check("ar_async_grant", int'(gv), 2);
    check("ar_async_hmaster", int'(hmaster), 1);
    check("ar_async_hmasterd", int'(hmasterd), 1);
    check("ar_async_mlock", int'(hmastlock), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(4'b0001, 4'h0, 2'd1, 3'd4, 1); cycle("ar4");
    check("ar_cnt_zero_grant", int'(gv), 1);

    // all masters requesting with SINGLE transfers
    reset_pulse();
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 4'h0, 2'd2, 3'd0, 1); cycle("all");
`ifdef AHB_ARB_ROUND_ROBIN_EN
      exp_rr = 1 << ((2 + k) % 4);
`else
      exp_rr = 1;
`endif
      check($sformatf("all%0d_grant", k), int'(gv), exp_rr);
    end

    // randomized traffic against the model
    reset_pulse();
    for (int n = 0; n < 600; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
